reorder_buffer: RTL and testbench

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/reorder_buffer_pkg.sv | 19 +
 rtl/reorder_buffer.sv | 137 +++++++++++++
 tb/tb_reorder_buffer.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared definitions for the reorder buffer: tag width, entry kinds and pointer helper.
package reorder_buffer_pkg;

   localparam int unsigned ROB_WIDTH = 4;
   localparam logic [ROB_WIDTH-1:0] ZERO_ROB = '0;

   typedef enum logic [1:0] {
      KindAlu    = 2'd0,
      KindStore  = 2'd1,
      KindBranch = 2'd2,
      KindJal    = 2'd3
   } rob_kind_e;

   function automatic logic [ROB_WIDTH-1:0] rob_next(input logic [ROB_WIDTH-1:0] ptr,
                                                     input int unsigned          size);
      return (32'(ptr) == size - 1) ? ZERO_ROB : ptr + 1'b1;
   endfunction

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: dispatch at tail, CDB completion by tag, commit/flush from head.
module reorder_buffer
   import reorder_buffer_pkg::*;
#(
   parameter int unsigned ROB_SIZE = 16
) (
   input  logic                 in_clk,
   input  logic                 in_rst_n,
   input  logic                 in_rdy,
   input  logic                 in_dispatch_enable,
   input  logic [4:0]           in_dispatch_rd,
   input  logic [1:0]           in_dispatch_kind,
   output logic [ROB_WIDTH-1:0] out_dispatch_tag,
   output logic                 out_full,
   input  logic [ROB_WIDTH-1:0] in_query_rs_tag,
   input  logic [ROB_WIDTH-1:0] in_query_rt_tag,
   output logic                 out_query_rs_ready,
   output logic [31:0]          out_query_rs_value,
   output logic                 out_query_rt_ready,
   output logic [31:0]          out_query_rt_value,
   input  logic                 in_cdb_enable,
   input  logic [ROB_WIDTH-1:0] in_cdb_tag,
   input  logic [31:0]          in_cdb_value,
   input  logic                 in_cdb_mispredict,
   input  logic [31:0]          in_cdb_target,
   output logic                 out_commit_enable,
   output logic [4:0]           out_commit_rd,
   output logic [31:0]          out_commit_value,
   output logic [ROB_WIDTH-1:0] out_commit_tag,
   output logic                 out_store_commit_enable,
   output logic                 out_flush_enable,
   output logic [31:0]          out_flush_pc
);

   localparam int unsigned CntW = ROB_WIDTH + 1;

   logic [ROB_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
   logic [CntW-1:0]      count_q, count_d;
   logic [ROB_SIZE-1:0]  busy_q, ready_q, mispredict_q;
   logic [31:0]          value_q  [ROB_SIZE];
   logic [31:0]          target_q [ROB_SIZE];
   logic [4:0]           rd_q     [ROB_SIZE];
   rob_kind_e            kind_q   [ROB_SIZE];

   logic full, commit_go, flush_go, dispatch_go, cdb_go, head_no_rd;
   logic rs_hit, rt_hit;

   assign full        = (count_q == CntW'(ROB_SIZE));
   assign commit_go   = in_rdy & (count_q != '0) & ready_q[head_q];
   assign flush_go    = commit_go & mispredict_q[head_q];
   // A flush kills whatever else arrives in the same cycle.
   assign dispatch_go = in_rdy & in_dispatch_enable & ~full & ~flush_go;
   assign cdb_go      = in_rdy & in_cdb_enable & busy_q[in_cdb_tag] & ~flush_go;
   assign head_no_rd  = (kind_q[head_q] == KindStore) | (kind_q[head_q] == KindBranch);

   assign out_dispatch_tag = tail_q;
   assign out_full         = full;

   assign rs_hit             = in_cdb_enable & (in_cdb_tag == in_query_rs_tag);
   assign rt_hit             = in_cdb_enable & (in_cdb_tag == in_query_rt_tag);
   assign out_query_rs_ready = ready_q[in_query_rs_tag] | rs_hit;
   assign out_query_rs_value = rs_hit ? in_cdb_value : value_q[in_query_rs_tag];
   assign out_query_rt_ready = ready_q[in_query_rt_tag] | rt_hit;
   assign out_query_rt_value = rt_hit ? in_cdb_value : value_q[in_query_rt_tag];

   assign out_commit_enable       = commit_go;
   assign out_commit_rd           = (commit_go & ~head_no_rd) ? rd_q[head_q] : 5'd0;
   assign out_commit_value        = commit_go ? value_q[head_q] : 32'd0;
   assign out_commit_tag          = commit_go ? head_q : ZERO_ROB;
   assign out_store_commit_enable = commit_go & (kind_q[head_q] == KindStore);
   assign out_flush_enable        = flush_go;
   assign out_flush_pc            = flush_go ? target_q[head_q] : 32'd0;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush_go) begin
         head_d  = ZERO_ROB;
         tail_d  = ZERO_ROB;
         count_d = '0;
      end else begin
         if (commit_go)   head_d = rob_next(head_q, ROB_SIZE);
         if (dispatch_go) tail_d = rob_next(tail_q, ROB_SIZE);
         unique case ({dispatch_go, commit_go})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge in_clk) begin
      if (!in_rst_n) begin
         head_q       <= ZERO_ROB;
         tail_q       <= ZERO_ROB;
         count_q      <= '0;
         busy_q       <= '0;
         ready_q      <= '0;
         mispredict_q <= '0;
         for (int i = 0; i < int'(ROB_SIZE); i++) begin
            value_q[i]  <= 32'd0;
            target_q[i] <= 32'd0;
            rd_q[i]     <= 5'd0;
            kind_q[i]   <= KindAlu;
         end
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         if (flush_go) begin
            busy_q       <= '0;
            ready_q      <= '0;
            mispredict_q <= '0;
         end else begin
            if (cdb_go) begin
               ready_q[in_cdb_tag]      <= 1'b1;
               mispredict_q[in_cdb_tag] <= in_cdb_mispredict;
               target_q[in_cdb_tag]     <= in_cdb_target;
               if (kind_q[in_cdb_tag] != KindStore) value_q[in_cdb_tag] <= in_cdb_value;
            end
            if (dispatch_go) begin
               busy_q[tail_q]       <= 1'b1;
               ready_q[tail_q]      <= 1'b0;
               mispredict_q[tail_q] <= 1'b0;
               rd_q[tail_q]         <= in_dispatch_rd;
               kind_q[tail_q]       <= rob_kind_e'(in_dispatch_kind);
            end
            if (commit_go) begin
               busy_q[head_q]  <= 1'b0;
               ready_q[head_q] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed-vector bench for reorder_buffer: each task drives a scenario and checks inline.
module tb_reorder_buffer;

   logic        in_clk, in_rst_n, in_rdy;
   logic        in_dispatch_enable;
   logic [4:0]  in_dispatch_rd;
   logic [1:0]  in_dispatch_kind;
   logic [3:0]  out_dispatch_tag;
   logic        out_full;
   logic [3:0]  in_query_rs_tag, in_query_rt_tag;
   logic        out_query_rs_ready, out_query_rt_ready;
   logic [31:0] out_query_rs_value, out_query_rt_value;
   logic        in_cdb_enable;
   logic [3:0]  in_cdb_tag;
   logic [31:0] in_cdb_value;
   logic        in_cdb_mispredict;
   logic [31:0] in_cdb_target;
   logic        out_commit_enable;
   logic [4:0]  out_commit_rd;
   logic [31:0] out_commit_value;
   logic [3:0]  out_commit_tag;
   logic        out_store_commit_enable;
   logic        out_flush_enable;
   logic [31:0] out_flush_pc;

   int checks = 0;
   int errors = 0;

   reorder_buffer #(.ROB_SIZE(16)) dut (
      .in_clk(in_clk), .in_rst_n(in_rst_n), .in_rdy(in_rdy),
      .in_dispatch_enable(in_dispatch_enable), .in_dispatch_rd(in_dispatch_rd),
      .in_dispatch_kind(in_dispatch_kind), .out_dispatch_tag(out_dispatch_tag),
      .out_full(out_full),
      .in_query_rs_tag(in_query_rs_tag), .in_query_rt_tag(in_query_rt_tag),
      .out_query_rs_ready(out_query_rs_ready), .out_query_rs_value(out_query_rs_value),
      .out_query_rt_ready(out_query_rt_ready), .out_query_rt_value(out_query_rt_value),
      .in_cdb_enable(in_cdb_enable), .in_cdb_tag(in_cdb_tag), .in_cdb_value(in_cdb_value),
      .in_cdb_mispredict(in_cdb_mispredict), .in_cdb_target(in_cdb_target),
      .out_commit_enable(out_commit_enable), .out_commit_rd(out_commit_rd),
      .out_commit_value(out_commit_value), .out_commit_tag(out_commit_tag),
      .out_store_commit_enable(out_store_commit_enable),
      .out_flush_enable(out_flush_enable), .out_flush_pc(out_flush_pc)
   );

   initial in_clk = 1'b0;
   always #5 in_clk = ~in_clk;

   task automatic tick();
      @(posedge in_clk);
      #1;
   endtask

   task automatic idle();
      in_rdy = 1'b1;
      in_dispatch_enable = 1'b0; in_dispatch_rd = 5'd0; in_dispatch_kind = 2'd0;
      in_query_rs_tag = 4'd0; in_query_rt_tag = 4'd0;
      in_cdb_enable = 1'b0; in_cdb_tag = 4'd0; in_cdb_value = 32'd0;
      in_cdb_mispredict = 1'b0; in_cdb_target = 32'd0;
   endtask

   task automatic do_reset();
      idle();
      in_rst_n = 1'b0;
      tick();
      in_rst_n = 1'b1;
   endtask

   task automatic dispatch(input logic [4:0] rd, input logic [1:0] kind);
      in_dispatch_enable = 1'b1; in_dispatch_rd = rd; in_dispatch_kind = kind;
      tick();
      in_dispatch_enable = 1'b0;
   endtask

   task automatic cdb(input logic [3:0] tag, input logic [31:0] val);
      in_cdb_enable = 1'b1; in_cdb_tag = tag; in_cdb_value = val;
   endtask

   task automatic test_reset();
      idle();
      in_rst_n = 1'b0;
      in_dispatch_enable = 1'b1; in_dispatch_rd = 5'd5;
      tick(); tick();
      checks++; if (out_dispatch_tag !== 4'd0) begin errors++;
         $display("FAIL reset_tag got %0h want 0", out_dispatch_tag); end
      checks++; if (out_full !== 1'b0) begin errors++;
         $display("FAIL reset_full got %0b want 0", out_full); end
      checks++; if ({out_commit_enable, out_store_commit_enable, out_flush_enable} !== 3'b000)
         begin errors++; $display("FAIL reset_enables got %0b want 000",
            {out_commit_enable, out_store_commit_enable, out_flush_enable}); end
      checks++; if ({out_commit_rd, out_commit_value, out_commit_tag, out_flush_pc} !== 73'd0)
         begin errors++; $display("FAIL reset_data got %0h want 0",
            {out_commit_rd, out_commit_value, out_commit_tag, out_flush_pc}); end
      checks++; if ({out_query_rs_ready, out_query_rs_value} !== 33'd0) begin errors++;
         $display("FAIL reset_query got %0h want 0", {out_query_rs_ready, out_query_rs_value});
      end
      idle();
      in_rst_n = 1'b1;
   endtask

   task automatic test_basic();
      do_reset();
      checks++; if (out_dispatch_tag !== 4'd0) begin errors++;
         $display("FAIL basic_tag got %0h want 0", out_dispatch_tag); end
      dispatch(5'd5, 2'd0);
      cdb(4'd0, 32'h1234);
      checks++; if (out_commit_enable !== 1'b0) begin errors++;
         $display("FAIL basic_same_cycle got %0b want 0", out_commit_enable); end
      tick();
      idle();
      checks++; if (out_commit_enable !== 1'b1) begin errors++;
         $display("FAIL basic_commit got %0b want 1", out_commit_enable); end
      checks++; if ({out_commit_rd, out_commit_value, out_commit_tag} !== {5'd5, 32'h1234, 4'd0})
         begin errors++; $display("FAIL basic_data got rd %0d val %0h tag %0d want 5 1234 0",
            out_commit_rd, out_commit_value, out_commit_tag); end
      tick();
      checks++; if (out_commit_enable !== 1'b0) begin errors++;
         $display("FAIL basic_once got %0b want 0", out_commit_enable); end
   endtask

   task automatic test_full();
      do_reset();
      for (int i = 0; i < 16; i++) dispatch(5'(i + 1), 2'd0);
      checks++; if ({out_full, out_dispatch_tag} !== {1'b1, 4'd0}) begin errors++;
         $display("FAIL full_set got full %0b tag %0d want 1 0", out_full, out_dispatch_tag); end
      dispatch(5'd31, 2'd0);
      checks++; if ({out_full, out_dispatch_tag} !== {1'b1, 4'd0}) begin errors++;
         $display("FAIL full_17th got full %0b tag %0d want 1 0", out_full, out_dispatch_tag); end
      cdb(4'd0, 32'hAA);
      tick();
      idle();
      checks++; if ({out_commit_enable, out_commit_rd, out_full} !== {1'b1, 5'd1, 1'b1})
         begin errors++; $display("FAIL full_commit got en %0b rd %0d full %0b want 1 1 1",
            out_commit_enable, out_commit_rd, out_full); end
      tick();
      checks++; if ({out_full, out_dispatch_tag, out_commit_enable} !== {1'b0, 4'd0, 1'b0})
         begin errors++; $display("FAIL full_clear got full %0b tag %0d en %0b want 0 0 0",
            out_full, out_dispatch_tag, out_commit_enable); end
      dispatch(5'd9, 2'd0);
      checks++; if ({out_full, out_dispatch_tag} !== {1'b1, 4'd1}) begin errors++;
         $display("FAIL full_wrap got full %0b tag %0d want 1 1", out_full, out_dispatch_tag); end
   endtask

   task automatic test_bypass();
      do_reset();
      for (int i = 0; i < 4; i++) dispatch(5'(i + 2), 2'd0);
      in_query_rs_tag = 4'd3; in_query_rt_tag = 4'd2;
      #1;
      checks++; if (out_query_rs_ready !== 1'b0) begin errors++;
         $display("FAIL bypass_idle got %0b want 0", out_query_rs_ready); end
      cdb(4'd3, 32'd7);
      #1;
      checks++; if ({out_query_rs_ready, out_query_rs_value, out_query_rt_ready}
            !== {1'b1, 32'd7, 1'b0}) begin errors++;
         $display("FAIL bypass_hit got rs %0b %0h rt %0b want 1 7 0",
            out_query_rs_ready, out_query_rs_value, out_query_rt_ready); end
      tick();
      in_cdb_enable = 1'b0;
      #1;
      checks++; if ({out_query_rs_ready, out_query_rs_value, out_commit_enable}
            !== {1'b1, 32'd7, 1'b0}) begin errors++;
         $display("FAIL bypass_stored got rs %0b %0h commit %0b want 1 7 0",
            out_query_rs_ready, out_query_rs_value, out_commit_enable); end
   endtask

   task automatic test_in_order();
      do_reset();
      dispatch(5'd3, 2'd0);
      dispatch(5'd4, 2'd0);
      cdb(4'd1, 32'h11);
      tick();
      in_cdb_enable = 1'b0;
      checks++; if (out_commit_enable !== 1'b0) begin errors++;
         $display("FAIL order_wait got %0b want 0", out_commit_enable); end
      cdb(4'd0, 32'h10);
      tick();
      in_cdb_enable = 1'b0;
      checks++; if ({out_commit_enable, out_commit_tag, out_commit_rd, out_commit_value}
            !== {1'b1, 4'd0, 5'd3, 32'h10}) begin errors++;
         $display("FAIL order_first got en %0b tag %0d rd %0d val %0h want 1 0 3 10",
            out_commit_enable, out_commit_tag, out_commit_rd, out_commit_value); end
      tick();
      checks++; if ({out_commit_enable, out_commit_tag, out_commit_rd, out_commit_value}
            !== {1'b1, 4'd1, 5'd4, 32'h11}) begin errors++;
         $display("FAIL order_second got en %0b tag %0d rd %0d val %0h want 1 1 4 11",
            out_commit_enable, out_commit_tag, out_commit_rd, out_commit_value); end
      tick();
      checks++; if (out_commit_enable !== 1'b0) begin errors++;
         $display("FAIL order_empty got %0b want 0", out_commit_enable); end
   endtask

   task automatic test_flush();
      do_reset();
      dispatch(5'd1, 2'd3);
      dispatch(5'd7, 2'd0);
      cdb(4'd1, 32'h77);
      tick();
      cdb(4'd0, 32'h44);
      in_cdb_mispredict = 1'b1; in_cdb_target = 32'h100;
      tick();
      idle();
      in_dispatch_enable = 1'b1; in_dispatch_rd = 5'd9;
      #1;
      checks++; if ({out_commit_enable, out_commit_rd, out_commit_value} !== {1'b1, 5'd1, 32'h44})
         begin errors++; $display("FAIL flush_commit got en %0b rd %0d val %0h want 1 1 44",
            out_commit_enable, out_commit_rd, out_commit_value); end
      checks++; if ({out_flush_enable, out_flush_pc} !== {1'b1, 32'h100}) begin errors++;
         $display("FAIL flush_pc got en %0b pc %0h want 1 100", out_flush_enable, out_flush_pc);
      end
      tick();
      in_dispatch_enable = 1'b0;
      checks++; if ({out_commit_enable, out_flush_enable, out_dispatch_tag, out_full}
            !== {1'b0, 1'b0, 4'd0, 1'b0}) begin errors++;
         $display("FAIL flush_empty got en %0b fl %0b tag %0d full %0b want 0 0 0 0",
            out_commit_enable, out_flush_enable, out_dispatch_tag, out_full); end
      tick();
      checks++; if (out_commit_enable !== 1'b0) begin errors++;
         $display("FAIL flush_younger got %0b want 0", out_commit_enable); end
   endtask

   task automatic test_store_branch();
      do_reset();
      dispatch(5'd5, 2'd1);
      dispatch(5'd6, 2'd2);
      cdb(4'd0, 32'h55);
      tick();
      cdb(4'd1, 32'h66);
      #1;
      checks++; if ({out_commit_enable, out_store_commit_enable, out_commit_rd}
            !== {1'b1, 1'b1, 5'd0}) begin errors++;
         $display("FAIL store_commit got en %0b st %0b rd %0d want 1 1 0",
            out_commit_enable, out_store_commit_enable, out_commit_rd); end
      tick();
      in_cdb_enable = 1'b0;
      checks++; if ({out_commit_enable, out_store_commit_enable, out_commit_rd, out_flush_enable}
            !== {1'b1, 1'b0, 5'd0, 1'b0}) begin errors++;
         $display("FAIL branch_commit got en %0b st %0b rd %0d fl %0b want 1 0 0 0",
            out_commit_enable, out_store_commit_enable, out_commit_rd, out_flush_enable); end
   endtask

   task automatic test_rdy_and_midreset();
      do_reset();
      dispatch(5'd8, 2'd0);
      cdb(4'd0, 32'h88);
      tick();
      in_cdb_enable = 1'b0;
      in_rdy = 1'b0;
      in_dispatch_enable = 1'b1;
      #1;
      checks++; if (out_commit_enable !== 1'b0) begin errors++;
         $display("FAIL rdy_commit got %0b want 0", out_commit_enable); end
      tick(); tick();
      in_dispatch_enable = 1'b0;
      checks++; if ({out_commit_enable, out_dispatch_tag} !== {1'b0, 4'd1}) begin errors++;
         $display("FAIL rdy_frozen got en %0b tag %0d want 0 1", out_commit_enable,
            out_dispatch_tag); end
      in_rdy = 1'b1;
      #1;
      checks++; if ({out_commit_enable, out_commit_value} !== {1'b1, 32'h88}) begin errors++;
         $display("FAIL rdy_resume got en %0b val %0h want 1 88", out_commit_enable,
            out_commit_value); end
      tick();
      dispatch(5'd2, 2'd0);
      dispatch(5'd3, 2'd0);
      cdb(4'd1, 32'h22);
      tick();
      idle();
      in_rst_n = 1'b0;
      tick();
      checks++; if ({out_commit_enable, out_flush_enable, out_store_commit_enable, out_full,
            out_dispatch_tag, out_commit_value} !== 40'd0) begin errors++;
         $display("FAIL midreset got en %0b fl %0b full %0b tag %0d val %0h want all 0",
            out_commit_enable, out_flush_enable, out_full, out_dispatch_tag, out_commit_value);
      end
      in_rst_n = 1'b1;
      tick();
      checks++; if ({out_commit_enable, out_dispatch_tag} !== {1'b0, 4'd0}) begin errors++;
         $display("FAIL midreset_after got en %0b tag %0d want 0 0", out_commit_enable,
            out_dispatch_tag); end
   endtask

   initial begin
      idle();
      in_rst_n = 1'b0;
      tick();
      test_reset();
      test_basic();
      test_full();
      test_bypass();
      test_in_order();
      test_flush();
      test_store_branch();
      test_rdy_and_midreset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
